operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Upstream front-end for the scheduled-datapath controller.
- Accepts a stream of operand words over a valid/ready handshake and writes them, one per cycle, into the datapath's operand input registers (indices 0..NUM_OPS-1).
- Once all operands are loaded, issues a one-cycle start pulse to the controller when it reports op_ready. It then waits for done_next, captures the datapath result and returns it over a valid/ready output handshake.

Parameters:
- DATA_W, 16, width of operands and result.
- NUM_OPS, 8, number of operand words per job; must be at least 2.
- IDX_W, 3, operand index width; must equal clog2(NUM_OPS).
- TIMEOUT, 64, maximum number of RUN cycles to wait for done_next.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  sequencer can accept an operand word.
- in_data  in  DATA_W  operand word.
- opnd_we  out  NUM_OPS  one-hot write enable to datapath operand registers.
- opnd_data  out  DATA_W  write data to datapath operand registers; equals in_data.
- op_ready  in  1  controller idle and able to take start.
- start  out  1  one-cycle start pulse to the controller.
- done_next  in  1  controller completion pulse; result register is valid in this cycle.
- res_data_in  in  DATA_W  datapath result register.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  captured result.
- busy  out  1  high in every state other than LOAD.
- err  out  1  sticky timeout flag.
- jobs_done  out  16  count of results accepted on the output.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high; ports are clk and rst.
- Reset values: state=LOAD, idx=0, tmo_cnt=0, out_data=0, out_valid=0, err=0, jobs_done=0. Combinational outputs (in_ready, opnd_we, start, busy) are 0 while rst=1. in_ready=1 on the first cycle after rst deasserts.
- States:
  - LOAD: in_ready=1.
    - On in_valid&&in_ready: opnd_we[idx]=1 in the same cycle, opnd_data=in_data, idx increments.
    - On accepting index NUM_OPS-1: idx returns to 0, next state ISSUE.
    - When no handshake occurs: opnd_we=0 and idx holds.
  - ISSUE: in_ready=0. start = op_ready, combinational.
    - On op_ready=1, next state RUN and tmo_cnt is cleared.
    - start is therefore high for exactly one cycle per job.
  - RUN: waits for done_next.
    - On done_next=1: out_data<=res_data_in, out_valid<=1, next state HOLD.
    - Otherwise tmo_cnt increments. When tmo_cnt==TIMEOUT-1 and done_next=0: err<=1, next state LOAD, result discarded, out_valid stays 0.
    - If done_next and the timeout coincide, done_next wins.
  - HOLD: out_valid=1, and out_data is stable until accepted.
    - On out_ready=1: out_valid<=0, jobs_done<=jobs_done+1, next state LOAD.
- jobs_done wraps from 0xFFFF to 0.
- err is cleared only by rst.
- done_next is ignored outside RUN. op_ready is ignored outside ISSUE. in_valid is ignored outside LOAD; a word offered then stays pending for the source.
- rst in any state, including mid-load or mid-RUN, aborts the job immediately and all reset values apply the next cycle. Any partially loaded operands are abandoned; the next job rewrites them starting from index 0.
- Latency:
  - Last operand accept to start is at least 1 cycle; it is exactly 1 cycle when op_ready=1.
  - done_next to out_valid is 1 cycle.
  - Output acceptance to in_ready=1 is 1 cycle.

Test Plan:
- Setup for all cases: NUM_OPS=8, DATA_W=16, TIMEOUT=64.
- Back-to-back load: in_valid=1 with data 0x0001..0x0008 on 8 consecutive cycles.
  - opnd_we = 0x01, 0x02, ..., 0x80 on consecutive cycles, with opnd_data matching.
  - in_ready=0 on the 9th cycle.
  - start=1 for exactly one cycle with op_ready=1.
- Delayed op_ready: in ISSUE, hold op_ready=0 for 5 cycles, then 1.
  - start=0 for those 5 cycles, start=1 in the op_ready cycle only, then state RUN.
- Result return: done_next=1 with res_data_in=0x1234, then out_ready=0 for 3 cycles, then 1.
  - out_valid=1 with out_data=0x1234 held stable for 4 cycles.
  - After the accept: out_valid=0, jobs_done=1, in_ready=1.
- Bubbled input: in_valid toggles 1,0,1,0,...
  - opnd_we is asserted only on handshake cycles, and idx advances only on those cycles.
  - During RUN, in_valid=1 gives in_ready=0 and opnd_we=0.
- Timeout: no done_next after start.
  - Exactly 64 RUN cycles, then err=1 and state LOAD.
  - out_valid never asserts and jobs_done is unchanged.
  - A subsequent normal job completes with err still 1.
- Reset mid-job: assert rst for 1 cycle after 3 operands are loaded, and separately while in HOLD.
  - Next cycle: out_valid=0, err=0, jobs_done=0, in_ready=1.
  - The next accepted word produces opnd_we=0x01.

Source files
------------

// File: rtl/operand_sequencer_if.sv
// Operand-in / result-out handshake bundle for the operand sequencer.
// Ports: in_valid/in_ready/in_data carry operand words toward the sequencer;
//        out_valid/out_ready/out_data carry the captured result away from it.
interface operand_sequencer_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   // master: the environment (operand source and result consumer)
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // slave: the sequencer itself
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/operand_sequencer.sv
// Loads NUM_OPS operand words into the datapath, pulses start, waits for done_next, returns the result.
// Latency: last operand -> start >= 1 cycle; done_next -> out_valid 1 cycle; out accept -> in_ready 1 cycle.
// Backpressure: in_ready only in LOAD; result held on out_valid/out_data until out_ready.
// Ports: clk/rst (sync, active-high); io = operand in / result out handshakes;
//        opnd_we/opnd_data = datapath operand register writes; op_ready/start/done_next/res_data_in =
//        controller and result interface; busy/err/jobs_done = status.
module operand_sequencer #(
   parameter int DATA_W  = 16,
   parameter int NUM_OPS = 8,
   parameter int IDX_W   = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   operand_sequencer_if.slave  io,
   output logic [NUM_OPS-1:0]  opnd_we,
   output logic [DATA_W-1:0]   opnd_data,
   input  logic                op_ready,
   output logic                start,
   input  logic                done_next,
   input  logic [DATA_W-1:0]   res_data_in,
   output logic                busy,
   output logic                err,
   output logic [15:0]         jobs_done
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      RUN   = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [TMO_W-1:0] tmo_cnt;
   logic [NUM_OPS-1:0] idx_onehot;

   assign idx_onehot = {{(NUM_OPS-1){1'b0}}, 1'b1} << idx;

   // Handshake-facing outputs are combinational so the operand write lands in
   // the same cycle as the accept and start follows op_ready directly. All are
   // forced low during reset.
   assign io.in_ready = !rst && (state == LOAD);
   assign opnd_we     = (io.in_ready && io.in_valid) ? idx_onehot : '0;
   assign opnd_data   = io.in_data;
   assign start       = !rst && (state == ISSUE) && op_ready;
   assign busy        = !rst && (state != LOAD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         idx          <= '0;
         tmo_cnt      <= '0;
         io.out_data  <= '0;
         io.out_valid <= 1'b0;
         err          <= 1'b0;
         jobs_done    <= '0;
      end else begin
         case (state)
            LOAD: begin
               // in_ready is high throughout LOAD, so in_valid alone is a handshake
               if (io.in_valid) begin
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     state <= ISSUE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (op_ready) begin
                  tmo_cnt <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               // done_next takes priority over an expiring timeout
               if (done_next) begin
                  io.out_data  <= res_data_in;
                  io.out_valid <= 1'b1;
                  state        <= HOLD;
               end else if (tmo_cnt == TMO_LAST) begin
                  err   <= 1'b1;
                  state <= LOAD;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (io.out_ready) begin
                  io.out_valid <= 1'b0;
                  jobs_done    <= jobs_done + 16'd1;
                  state        <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a queue scoreboard: stimulus pushes
// expected operand writes and results, a negedge monitor pops and compares them.
// Ports: drives the DUT through an operand_sequencer_if instance plus plain signals.
module tb_operand_sequencer;
   localparam int DATA_W  = 16;
   localparam int NUM_OPS = 8;
   localparam int IDX_W   = 3;
   localparam int TIMEOUT = 64;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_OPS-1:0] opnd_we;
   logic [DATA_W-1:0]  opnd_data;
   logic               op_ready;
   logic               start;
   logic               done_next;
   logic [DATA_W-1:0]  res_data_in;
   logic               busy;
   logic               err;
   logic [15:0]        jobs_done;

   operand_sequencer_if #(.DATA_W(DATA_W)) bus ();

   operand_sequencer #(
      .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .io(bus),
      .opnd_we(opnd_we), .opnd_data(opnd_data),
      .op_ready(op_ready), .start(start),
      .done_next(done_next), .res_data_in(res_data_in),
      .busy(busy), .err(err), .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic [23:0] exp_wr[$];   // {opnd_we, opnd_data}
   logic [15:0] exp_res[$];  // out_data at acceptance
   logic [15:0] exp_jobs = 16'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: any operand write or result handshake must match the next queued expectation.
   always @(negedge clk) begin
      if (opnd_we != '0) begin
         if (exp_wr.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL opnd_wr_unexpected: got we=%0h data=%0h expected none", opnd_we, opnd_data);
         end else begin
            chk("opnd_wr", {8'h0, opnd_we, opnd_data}, {8'h0, exp_wr.pop_front()});
         end
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exp_res.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL res_unexpected: got %0h expected none", bus.out_data);
         end else begin
            chk("res_data", {16'h0, bus.out_data}, {16'h0, exp_res.pop_front()});
         end
      end
   end

   // Load NUM_OPS words base..base+7; optionally idle one cycle between words.
   task automatic load_job(input logic [15:0] base, input bit bubble);
      for (int i = 0; i < NUM_OPS; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = base + 16'(i);
         exp_wr.push_back({8'(1 << i), base + 16'(i)});
         @(negedge clk);
         chk("ld_in_ready", {31'h0, bus.in_ready}, 32'h1);
         tick();
         if (bubble && i < NUM_OPS - 1) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 16'hFFFF;
            @(negedge clk);
            chk("bubble_we", {24'h0, opnd_we}, 32'h0);
            tick();
         end
      end
      bus.in_valid = 1'b0;
   endtask

   // ISSUE: hold op_ready low for wait_cyc cycles, then one start cycle.
   task automatic issue(input int wait_cyc);
      for (int i = 0; i < wait_cyc; i++) begin
         op_ready = 1'b0;
         @(negedge clk);
         chk("issue_wait_start", {31'h0, start}, 32'h0);
         chk("issue_in_ready", {31'h0, bus.in_ready}, 32'h0);
         tick();
      end
      op_ready = 1'b1;
      @(negedge clk);
      chk("issue_start", {31'h0, start}, 32'h1);
      chk("issue_busy", {31'h0, busy}, 32'h1);
      tick();
      op_ready = 1'b0;
   endtask

   // RUN cycle with done_next, then hold cycles with out_ready low, then accept.
   task automatic finish_job(input logic [15:0] res, input int hold);
      done_next   = 1'b1;
      res_data_in = res;
      op_ready    = 1'b1;  // ignored outside ISSUE
      exp_res.push_back(res);
      @(negedge clk);
      chk("run_start_low", {31'h0, start}, 32'h0);
      chk("run_out_valid", {31'h0, bus.out_valid}, 32'h0);
      tick();
      done_next   = 1'b0;
      op_ready    = 1'b0;
      res_data_in = 16'h0BAD;
      for (int i = 0; i < hold; i++) begin
         bus.out_ready = 1'b0;
         @(negedge clk);
         chk("hold_valid", {31'h0, bus.out_valid}, 32'h1);
         chk("hold_data", {16'h0, bus.out_data}, {16'h0, res});
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("acc_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("acc_data", {16'h0, bus.out_data}, {16'h0, res});
      tick();
      bus.out_ready = 1'b0;
      exp_jobs = exp_jobs + 16'd1;
      @(negedge clk);
      chk("post_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("post_jobs", {16'h0, jobs_done}, {16'h0, exp_jobs});
      chk("post_in_ready", {31'h0, bus.in_ready}, 32'h1);
      tick();
   endtask

   task automatic check_reset_state(input string nm);
      @(negedge clk);
      chk({nm, "_out_valid"}, {31'h0, bus.out_valid}, 32'h0);
      chk({nm, "_out_data"}, {16'h0, bus.out_data}, 32'h0);
      chk({nm, "_err"}, {31'h0, err}, 32'h0);
      chk({nm, "_jobs"}, {16'h0, jobs_done}, 32'h0);
      chk({nm, "_in_ready"}, {31'h0, bus.in_ready}, 32'h1);
      chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      op_ready = 1'b1; done_next = 1'b0; res_data_in = '0;
      tick();
      @(negedge clk);
      chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
      chk("rst_start", {31'h0, start}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      tick();
      rst = 1'b0;
      op_ready = 1'b0;
      check_reset_state("init");

      // Back-to-back load; 9th cycle still offers a word which must not be taken.
      load_job(16'h0001, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hDEAD;
      @(negedge clk);
      chk("ninth_in_ready", {31'h0, bus.in_ready}, 32'h0);
      tick();
      issue(0);
      bus.in_valid = 1'b0;
      finish_job(16'h1234, 3);

      // Delayed op_ready; a stray done_next during ISSUE is ignored.
      load_job(16'h0100, 1'b0);
      done_next = 1'b1;
      issue(5);
      done_next = 1'b0;
      finish_job(16'hBEEF, 0);

      // Bubbled load; a word offered during RUN stays pending.
      load_job(16'h0200, 1'b1);
      issue(1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h7777;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("run_in_ready", {31'h0, bus.in_ready}, 32'h0);
         chk("run_we", {24'h0, opnd_we}, 32'h0);
         tick();
      end
      bus.in_valid = 1'b0;
      finish_job(16'hA5A5, 1);

      // Timeout: exactly TIMEOUT RUN cycles, then err and back to LOAD.
      load_job(16'h0300, 1'b0);
      issue(0);
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || err !== 1'b0) begin
            chk("tmo_run_cycle", {29'h0, bus.in_ready, bus.out_valid, err}, 32'h0);
         end else begin
            n_chk++;
         end
         tick();
      end
      @(negedge clk);
      chk("tmo_err", {31'h0, err}, 32'h1);
      chk("tmo_in_ready", {31'h0, bus.in_ready}, 32'h1);
      chk("tmo_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("tmo_jobs", {16'h0, jobs_done}, {16'h0, exp_jobs});
      tick();
      load_job(16'h0400, 1'b0);
      issue(2);
      finish_job(16'h5A5A, 2);
      @(negedge clk);
      chk("err_sticky", {31'h0, err}, 32'h1);
      tick();

      // Reset after 3 operands loaded.
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'h0500 + 16'(i);
         exp_wr.push_back({8'(1 << i), 16'h0500 + 16'(i)});
         tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hEEEE;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_we", {24'h0, opnd_we}, 32'h0);
      chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'h0);
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      exp_jobs = 16'd0;
      check_reset_state("midload");
      load_job(16'h0600, 1'b0);
      issue(0);
      finish_job(16'h0F0F, 0);

      // Reset while holding a result.
      load_job(16'h0700, 1'b0);
      issue(0);
      done_next   = 1'b1;
      res_data_in = 16'hCAFE;
      tick();
      done_next = 1'b0;
      @(negedge clk);
      chk("hold_before_rst", {31'h0, bus.out_valid}, 32'h1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_jobs = 16'd0;
      check_reset_state("midhold");

      // First word after reset lands at index 0.
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0800;
      exp_wr.push_back({8'h01, 16'h0800});
      tick();
      bus.in_valid = 1'b0;
      tick();

      chk("wr_queue_empty", exp_wr.size(), 32'h0);
      chk("res_queue_empty", exp_res.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
